// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and sizing for the matmul energy-evaluation scheduler
package matmul_pkg;

  localparam int NUM_CHUNKS   = 64;
  localparam int ENERGY_WIDTH = 21;
  localparam int CHUNK_AW     = $clog2(NUM_CHUNKS);

  typedef logic [CHUNK_AW-1:0] chunk_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    EVAL,
    DONE
  } state_t;

endpackage

// File: rtl/matmul_rd_tracker.sv
// rtl/matmul_rd_tracker.sv - counts issued and returned chunk reads and the reads still in flight
module matmul_rd_tracker #(
  parameter int NUM_CHUNKS      = 64,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CW              = $clog2(NUM_CHUNKS + 1),
  parameter int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          issue,
  input  logic          ret,
  output logic [CW-1:0] issue_cnt,
  output logic [CW-1:0] ret_cnt,
  output logic [OW-1:0] outstanding
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
    end else if (clear) begin
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + CW'(1);
      if (ret)   ret_cnt   <= ret_cnt + CW'(1);
      // a grant and a return in the same cycle cancel out
      case ({issue, ret})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: rtl/matmul_sched.sv
// rtl/matmul_sched.sv - sequences J-matrix chunk reads for one energy evaluation and decides accept/abort
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int NUM_CHUNKS      = matmul_pkg::NUM_CHUNKS,
  parameter int ENERGY_WIDTH    = matmul_pkg::ENERGY_WIDTH,
  parameter int PIPE_LAT        = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int AW              = $clog2(NUM_CHUNKS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           early_stop_en,
  input  logic signed [ENERGY_WIDTH-1:0] energy_prev,
  output logic                           mem_req,
  output logic [AW-1:0]                  mem_addr,
  input  logic                           mem_gnt,
  input  logic                           mem_rvalid,
  output logic                           dp_clear,
  output logic                           dp_valid,
  output logic [AW-1:0]                  dp_chunk_idx,
  input  logic signed [ENERGY_WIDTH-1:0] energy_in,
  output logic                           busy,
  output logic                           done,
  output logic                           accept,
  output logic                           aborted,
  output logic signed [ENERGY_WIDTH-1:0] energy_out
);

  localparam int CW = $clog2(NUM_CHUNKS + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(NUM_CHUNKS);
  localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);
  localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT - 1);

  state_t        state_q, state_d;
  logic          abort_q;
  logic [DW-1:0] drain_cnt;
  logic [CW-1:0] issue_cnt, ret_cnt;
  logic [OW-1:0] outstanding;
  logic          in_fetch, abort_set;

  assign in_fetch  = (state_q == FETCH);
  assign abort_set = in_fetch && early_stop_en && (energy_in > energy_prev);

  // issuing stops on the same cycle the overrun is seen, not a cycle later
  assign mem_req      = in_fetch && (issue_cnt < LAST_CNT) && (outstanding < MAX_OUT)
                        && !abort_q && !abort_set;
  assign mem_addr     = issue_cnt[AW-1:0];
  assign dp_clear     = (state_q == CLEAR);
  assign dp_valid     = in_fetch && mem_rvalid;
  assign dp_chunk_idx = ret_cnt[AW-1:0];
  assign busy         = (state_q == CLEAR) || in_fetch || (state_q == DRAIN) || (state_q == EVAL);
  assign done         = (state_q == DONE);

  matmul_rd_tracker #(
    .NUM_CHUNKS      (NUM_CHUNKS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CW              (CW),
    .OW              (OW)
  ) u_rd_tracker (
    .clk         (clk),
    .rst         (rst),
    .clear       (dp_clear),
    .issue       (mem_req && mem_gnt),
    .ret         (dp_valid),
    .issue_cnt   (issue_cnt),
    .ret_cnt     (ret_cnt),
    .outstanding (outstanding)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = FETCH;
      FETCH:   if ((ret_cnt == LAST_CNT) || (abort_q && (outstanding == '0))) state_d = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_END) state_d = EVAL;
      EVAL:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      abort_q    <= 1'b0;
      drain_cnt  <= '0;
      accept     <= 1'b0;
      aborted    <= 1'b0;
      energy_out <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        CLEAR: abort_q <= 1'b0;
        FETCH: begin
          if (abort_set) abort_q <= 1'b1;
          drain_cnt <= '0;
        end
        DRAIN: drain_cnt <= drain_cnt + DW'(1);
        EVAL: begin
          energy_out <= energy_in;
          accept     <= !abort_q && (energy_in < energy_prev);
          aborted    <= abort_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matmul_sched.md
MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 Parameter NUM_CHUNKS, default 64: J-matrix chunk reads per energy evaluation.
REQ-002 Parameter ENERGY_WIDTH, default 21: signed energy width.
REQ-003 Parameter PIPE_LAT, default 2: datapath cycles from last chunk accepted to final energy_in valid.
REQ-004 Parameter MAX_OUTSTANDING, default 2: maximum granted-but-unreturned reads.
REQ-005 Derived AW = $clog2(NUM_CHUNKS), default 6.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to evaluate a new sigma.
REQ-009 early_stop_en  in  1  enables abort on partial-energy overrun.
REQ-010 energy_prev  in  ENERGY_WIDTH  signed energy of the current accepted state.
REQ-011 mem_req  out  1  chunk read request.
REQ-012 mem_addr  out  AW  chunk index being requested.
REQ-013 mem_gnt  in  1  request accepted this cycle.
REQ-014 mem_rvalid  in  1  chunk data returned; in order, one per grant.
REQ-015 dp_clear  out  1  one-cycle datapath accumulator clear.
REQ-016 dp_valid  out  1  chunk on the datapath input is valid this cycle.
REQ-017 dp_chunk_idx  out  AW  index of the chunk presented with dp_valid.
REQ-018 energy_in  in  ENERGY_WIDTH  signed running energy from the datapath.
REQ-019 busy  out  1  high from the cycle after start is accepted until done.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 accept  out  1  valid with done; 1 means energy_out < energy_prev.
REQ-022 aborted  out  1  valid with done; 1 means early stop occurred.
REQ-023 energy_out  out  ENERGY_WIDTH  final energy, held until the next start.

Function
REQ-024 FSM states IDLE, CLEAR, FETCH, DRAIN, EVAL, DONE shall be used.
REQ-025 IDLE: start=1 leads to CLEAR; start shall be ignored in every other state.
REQ-026 CLEAR shall last 1 cycle with dp_clear=1, zero issue_cnt and ret_cnt, then enter FETCH.
REQ-027 FETCH: mem_req=1 iff issue_cnt < NUM_CHUNKS, outstanding < MAX_OUTSTANDING and no abort is pending.
REQ-028 mem_addr shall equal issue_cnt; mem_req&mem_gnt shall increment issue_cnt and outstanding.
REQ-029 mem_req shall stay high with a stable mem_addr until granted.
REQ-030 dp_valid shall equal mem_rvalid in FETCH (combinational), with dp_chunk_idx = ret_cnt; each rvalid shall increment ret_cnt and decrement outstanding.
REQ-031 Simultaneous grant and rvalid shall leave outstanding unchanged.
REQ-032 Abort: in FETCH, early_stop_en=1 and signed energy_in > energy_prev shall set the abort flag; issuing shall stop, and the block shall wait for outstanding = 0.
REQ-033 FETCH exits to DRAIN when ret_cnt = NUM_CHUNKS, or when the abort flag is set and outstanding = 0.
REQ-034 DRAIN shall last exactly PIPE_LAT cycles, then enter EVAL.
REQ-035 EVAL, 1 cycle: energy_out <= energy_in; accept <= !abort && (energy_in < energy_prev), signed compare; aborted <= abort flag.
REQ-036 DONE, 1 cycle: done=1, then IDLE; busy=1 in CLEAR through EVAL.
REQ-037 mem_rvalid in IDLE, CLEAR or DONE shall be ignored and shall not increment counters.
REQ-038 Equal energies (energy_in == energy_prev) shall give accept=0 and shall not abort.

Reset
REQ-039 rst=1 shall immediately force IDLE, counters and abort flag to 0, and all outputs to 0, including energy_out.
REQ-040 Reset mid-FETCH shall discard in-flight reads, and no done shall be emitted for the interrupted run.

Structure
REQ-041 Shared package matmul_pkg shall hold the state enum type, NUM_CHUNKS, ENERGY_WIDTH and the chunk-index type.
REQ-042 The issue/return tracking shall be one sub-module, matmul_rd_tracker (issue_cnt, ret_cnt, outstanding); everything else shall be flat.

Verification
REQ-043 mem_gnt tied 1, rvalid one cycle after grant, energy_in = -5 final, energy_prev = 10 -> 64 dp_valid pulses with idx 0..63, then done with accept=1 and energy_out = -5.
REQ-044 Random mem_gnt stalls (50%) and rvalid delay 1-4 -> outstanding never exceeds 2, mem_addr stable while stalled, idx strictly 0..63.
REQ-045 early_stop_en=1, energy_in = 12 > energy_prev = 10 at chunk 20 -> no further mem_req, in-flight reads drained, done with aborted=1 and accept=0.
REQ-046 Final energy_in == energy_prev = 7 -> accept=0, aborted=0.
REQ-047 rst asserted at chunk 30, then a new start -> outputs 0 immediately, no done for the old run, new run starts at idx 0.
REQ-048 start pulsed while busy -> ignored, exactly one done per accepted start.
